// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
//
// Asynchronous serial receiver (start bit, DATA_WIDTH data bits LSB first,
// one stop bit, no parity). The rx pin is brought into the clk domain through
// a two-flop synchroniser. Each bit is sampled once, at its midpoint, using a
// baud counter.
//
// A correctly framed word is presented on data_out with a one-cycle
// data_valid strobe, which is suitable for driving a load register's ld.
// A stop bit sampled low gives a one-cycle frame_err strobe and leaves
// data_out untouched. The receiver then waits in BREAK until the line
// returns high, so a held-low line cannot retrigger a frame.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (>= 4)
//   DATA_WIDTH    data bits per frame
//
// Ports
//   clk         in   system clock, all logic on posedge
//   reset       in   synchronous, active-high
//   rx          in   asynchronous serial input, idle high
//   data_out    out  last correctly framed word
//   data_valid  out  1-cycle strobe, data_out updated this cycle
//   frame_err   out  1-cycle strobe, stop bit sampled low
//   busy        out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module uart_rx_byte #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  frame_err,
   output logic                  busy
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   // START waits half a bit. The other states wait a full bit. The counter
   // value on the sampling cycle is one less than the wait length, because
   // the counter starts at 0 on the first cycle of each state.
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   state_t                  state_r;
   logic [CNT_W-1:0]        baud_cnt_r;
   logic [BIT_W-1:0]        bit_cnt_r;
   logic [DATA_WIDTH-1:0]   shift_r;
   logic                    sync1_r;
   logic                    sync2_r;
   logic                    rx_s;

   // Shift one received bit into the top of the word. Bits arrive LSB
   // first, so after DATA_WIDTH shifts the first bit sits in bit 0.
   function automatic logic [DATA_WIDTH-1:0] shift_in(
      input logic [DATA_WIDTH-1:0] cur,
      input logic                  b
   );
      logic [DATA_WIDTH:0] tmp;
      tmp = {b, cur};
      return tmp[DATA_WIDTH:1];
   endfunction

   // Two-flop synchroniser. Reset loads the idle-high level, so no false
   // start edge appears when reset is released.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= rx;
         sync2_r <= sync1_r;
      end
   end

   assign rx_s = sync2_r;

   // Receive FSM, including the baud and bit counters and the registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         baud_cnt_r <= {CNT_W{1'b0}};
         bit_cnt_r  <= {BIT_W{1'b0}};
         shift_r    <= {DATA_WIDTH{1'b0}};
         data_out   <= {DATA_WIDTH{1'b0}};
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         // Strobes default low, so each one lasts exactly one cycle.
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               baud_cnt_r <= {CNT_W{1'b0}};
               bit_cnt_r  <= {BIT_W{1'b0}};
               if (!rx_s) begin
                  state_r <= ST_START;
                  busy    <= 1'b1;
               end else begin
                  busy    <= 1'b0;
               end
            end

            ST_START: begin
               if (baud_cnt_r == HALF_LAST) begin
                  baud_cnt_r <= {CNT_W{1'b0}};
                  bit_cnt_r  <= {BIT_W{1'b0}};
                  if (!rx_s) begin
                     state_r <= ST_DATA;
                  end else begin
                     // The line is high again at mid start bit, so this was
                     // a glitch. Drop it silently.
                     state_r <= ST_IDLE;
                     busy    <= 1'b0;
                  end
               end else begin
                  baud_cnt_r <= baud_cnt_r + 1'b1;
               end
            end

            ST_DATA: begin
               if (baud_cnt_r == FULL_LAST) begin
                  baud_cnt_r <= {CNT_W{1'b0}};
                  shift_r    <= shift_in(shift_r, rx_s);
                  if (bit_cnt_r == BIT_LAST) begin
                     bit_cnt_r <= {BIT_W{1'b0}};
                     state_r   <= ST_STOP;
                  end else begin
                     bit_cnt_r <= bit_cnt_r + 1'b1;
                  end
               end else begin
                  baud_cnt_r <= baud_cnt_r + 1'b1;
               end
            end

            ST_STOP: begin
               if (baud_cnt_r == FULL_LAST) begin
                  baud_cnt_r <= {CNT_W{1'b0}};
                  if (rx_s) begin
                     // IDLE is re-entered halfway through the stop bit. A
                     // start bit that directly follows the stop bit is
                     // therefore still seen.
                     data_out   <= shift_r;
                     data_valid <= 1'b1;
                     state_r    <= ST_IDLE;
                     busy       <= 1'b0;
                  end else begin
                     frame_err  <= 1'b1;
                     state_r    <= ST_BREAK;
                  end
               end else begin
                  baud_cnt_r <= baud_cnt_r + 1'b1;
               end
            end

            ST_BREAK: begin
               // Hold until the line is released. Only a high level exits
               // this state, so a line held low cannot start a new frame.
               baud_cnt_r <= {CNT_W{1'b0}};
               if (rx_s) begin
                  state_r <= ST_IDLE;
                  busy    <= 1'b0;
               end else begin
                  state_r <= ST_BREAK;
               end
            end

            default: begin
               state_r    <= ST_IDLE;
               baud_cnt_r <= {CNT_W{1'b0}};
               bit_cnt_r  <= {BIT_W{1'b0}};
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule
